// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the synchronous imem, buffers the
// returning {pc,instr} pairs and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_buf_pc    [BUF_DEPTH];
  logic [31:0]   r_buf_instr [BUF_DEPTH];

  logic [CW:0]   w_occ;
  logic [31:0]   w_redir_pc;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_lo;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (32'(p) == BUF_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  assign w_unused_lo = ^redirect_pc[1:0];
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

  // Occupancy counts the read in flight so the buffer can never overflow.
  assign w_occ   = {1'b0, r_count}
                 + {{CW{1'b0}}, r_inflight};
  assign w_issue = rst_n
                 & (redirect_valid
                   | (w_occ < (CW+1)'(BUF_DEPTH)));

  assign imem_en = w_issue;

  always_comb begin
    imem_pc = r_fetch_pc;
    if (!rst_n)
      imem_pc = RESET_PC;
    else if (redirect_valid)
      imem_pc = w_redir_pc;
  end

  assign if_valid = rst_n & (r_count != '0);
  assign if_pc    = if_valid
                  ? r_buf_pc[r_head] : '0;
  assign if_instr = if_valid
                  ? r_buf_instr[r_head] : '0;

  // A redirect kills both the returning read and the head handshake.
  assign w_push = rst_n & r_inflight
                & ~redirect_valid;
  assign w_pop  = if_valid & id_ready
                & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]    <= r_inflight_pc;
      r_buf_instr[r_tail] <= imem_instr;
    end
    if (w_issue)
      r_inflight_pc <= imem_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      assert (!(w_push
        && 32'(r_count) == BUF_DEPTH));
      r_inflight <= w_issue;
      if (w_issue)
        r_fetch_pc <= imem_pc + 32'd4;
      if (redirect_valid) begin
        r_count <= '0;
        r_tail  <= r_head;
      end else begin
        if (w_push)
          r_tail <= nxt(r_tail);
        if (w_pop)
          r_head <= nxt(r_head);
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table plus randomized run
// checked against a program-order stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(
    input logic [31:0] a
  );
    if (a == 32'h0)  return 32'h0010_0313;
    if (a == 32'h40) return 32'h0030_0693;
    return a * 32'h9E37_79B1 + 32'h13;
  endfunction

  // imem_sync: one-cycle registered read, held while en=0
  always @(posedge clk)
    if (imem_en) imem_instr <= rom(imem_pc);

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        een;
    logic [31:0] eipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, input logic rv,
    input logic [31:0] rpc, input logic rdy,
    input logic ev, input logic [31:0] epc,
    input logic een, input logic [31:0] eipc
  );
    vec_t r;
    r.rst = rst; r.rv = rv; r.rpc = rpc;
    r.rdy = rdy; r.ev = ev; r.epc = epc;
    r.een = een; r.eipc = eipc;
    return r;
  endfunction

  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        prev_stall;
  int          idle;

  initial begin
    // reset, then gapless stream (T1)
    tbl.push_back(v(0,0,0,1, 0,0,        0,0));
    tbl.push_back(v(1,0,0,1, 0,0,        1,0));
    tbl.push_back(v(1,0,0,1, 0,0,        1,4));
    tbl.push_back(v(1,0,0,1, 1,0,        1,8));
    tbl.push_back(v(1,0,0,1, 1,4,        1,12));
    tbl.push_back(v(1,0,0,1, 1,8,        1,16));
    // 6-cycle stall and release (T2)
    tbl.push_back(v(1,0,0,0, 1,12,       1,20));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1,0,0,0, 1,12,     0,24));
    tbl.push_back(v(1,0,0,1, 1,12,       0,24));
    tbl.push_back(v(1,0,0,1, 1,16,       1,24));
    tbl.push_back(v(1,0,0,1, 1,20,       1,28));
    tbl.push_back(v(1,0,0,1, 1,24,       1,32));
    // redirect to 0x40 (T3)
    tbl.push_back(v(1,1,32'h40,1, 1,28,  1,32'h40));
    tbl.push_back(v(1,0,0,1, 0,0,        1,32'h44));
    tbl.push_back(v(1,0,0,1, 1,32'h40,   1,32'h48));
    tbl.push_back(v(1,0,0,1, 1,32'h44,   1,32'h4C));
    // fill, then back-to-back redirects (T4)
    tbl.push_back(v(1,0,0,0, 1,32'h48,   1,32'h50));
    tbl.push_back(v(1,0,0,0, 1,32'h48,   0,32'h54));
    tbl.push_back(v(1,0,0,0, 1,32'h48,   0,32'h54));
    tbl.push_back(v(1,1,32'h40,0, 1,32'h48, 1,32'h40));
    tbl.push_back(v(1,1,32'h20,1, 0,0,   1,32'h20));
    tbl.push_back(v(1,0,0,1, 0,0,        1,32'h24));
    tbl.push_back(v(1,0,0,1, 1,32'h20,   1,32'h28));
    tbl.push_back(v(1,0,0,1, 1,32'h24,   1,32'h2C));
    // unaligned redirect at top of memory (T5)
    tbl.push_back(v(1,1,32'hFFFF_FFFE,1, 1,32'h28,
                    1,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,0,1, 0,0,        1,0));
    tbl.push_back(v(1,0,0,1, 1,32'hFFFF_FFFC, 1,4));
    tbl.push_back(v(1,0,0,1, 1,0,        1,8));
    // reset with full buffer, beating a redirect (T6)
    tbl.push_back(v(1,0,0,0, 1,4,        1,12));
    tbl.push_back(v(1,0,0,0, 1,4,        0,16));
    tbl.push_back(v(0,1,32'h80,0, 0,0,   0,0));
    tbl.push_back(v(1,0,0,1, 0,0,        1,0));
    tbl.push_back(v(1,0,0,1, 0,0,        1,4));
    tbl.push_back(v(1,0,0,1, 1,0,        1,8));

    foreach (tbl[k]) begin
      rst_n          = tbl[k].rst;
      redirect_valid = tbl[k].rv;
      redirect_pc    = tbl[k].rpc;
      id_ready       = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("v%0d if_valid", k),
          32'(if_valid), 32'(tbl[k].ev));
      chk($sformatf("v%0d if_pc", k),
          if_pc, tbl[k].ev ? tbl[k].epc : 32'h0);
      chk($sformatf("v%0d if_instr", k), if_instr,
          tbl[k].ev ? rom(tbl[k].epc) : 32'h0);
      chk($sformatf("v%0d imem_en", k),
          32'(imem_en), 32'(tbl[k].een));
      chk($sformatf("v%0d imem_pc", k),
          imem_pc, tbl[k].eipc);
      @(posedge clk);
      #1;
    end

    // randomized run vs program-order stream model
    exp_pc     = '0;
    prev_stall = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    idle       = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c == 0) ? 1'b0
            : ($urandom_range(0, 63) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0)
                  ? (32'hFFFF_FFF0
                    | $urandom_range(0, 15))
                  : $urandom;
      id_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (!rst_n) begin
        chk("rst if_valid", 32'(if_valid), 0);
        chk("rst imem_en", 32'(imem_en), 0);
        chk("rst imem_pc", imem_pc, 0);
        exp_pc     = '0;
        prev_stall = 1'b0;
        idle       = 0;
      end else begin
        if (prev_stall) begin
          chk("stall valid", 32'(if_valid), 1);
          chk("stall pc", if_pc, prev_pc);
          chk("stall instr", if_instr, prev_instr);
        end
        if (if_valid) begin
          chk("stream pc", if_pc, exp_pc);
          chk("stream instr", if_instr, rom(if_pc));
          idle = 0;
        end else begin
          chk("idle pc", if_pc, 0);
          chk("idle instr", if_instr, 0);
          if (!redirect_valid) begin
            idle++;
            chk("bubble bound",
                32'(idle <= 2), 1);
          end
        end
        if (redirect_valid) begin
          chk("redir en", 32'(imem_en), 1);
          chk("redir pc", imem_pc,
              {redirect_pc[31:2], 2'b00});
          exp_pc = {redirect_pc[31:2], 2'b00};
          idle   = 0;
        end else if (if_valid && id_ready) begin
          exp_pc = exp_pc + 32'd4;
        end
        prev_stall = if_valid & !id_ready
                   & !redirect_valid;
      end
      prev_pc    = if_pc;
      prev_instr = if_instr;
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
